// File: rtl/roi_pkg.sv
// Shared types and coordinate-field helpers for the ROI pad path.
package roi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  localparam int unsigned X_MSB = 26;
  localparam int unsigned X_LSB = 16;
  localparam int unsigned Y_MSB = 9;
  localparam int unsigned Y_LSB = 0;
  localparam int unsigned XW    = X_MSB - X_LSB + 1;
  localparam int unsigned YW    = Y_MSB - Y_LSB + 1;

  function automatic logic [XW-1:0] get_x(input logic [31:0] w);
    return w[X_MSB:X_LSB];
  endfunction

  function automatic logic [YW-1:0] get_y(input logic [31:0] w);
    return w[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/roi_pad_axis_if.sv
// AXI-Stream bundle used for both the ROI input and the full-frame output.
interface roi_pad_axis_if #(
  parameter int unsigned BIT_D = 8
);
  logic [BIT_D-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic             tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream output register; holds data/last/user while stalled.
module axis_out_reg #(
  parameter int unsigned BIT_D = 8
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             load_i,
  input  logic [BIT_D-1:0] data_i,
  input  logic             last_i,
  input  logic             user_i,
  output logic             ld_rdy_o,
  roi_pad_axis_if.master   m_axis
);

  assign ld_rdy_o = !m_axis.tvalid || m_axis.tready;

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
    end else if (load_i) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata  <= data_i;
      m_axis.tlast  <= last_i;
      m_axis.tuser  <= user_i;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/roi_pad_axis.sv
// Rebuilds a full WIDTH x HEIGHT raster from an ROI pixel stream, padding with FILL.
// Define ROI_BORDER_EN to paint the 1-pixel ring around the ROI with BORDER.
module roi_pad_axis
  import roi_pkg::*;
#(
  parameter int unsigned     WIDTH  = 800,
  parameter int unsigned     HEIGHT = 600,
  parameter int unsigned     BIT_D  = 8,
  parameter int unsigned     BIT_C  = 32,
  parameter logic [BIT_D-1:0] FILL  = '0,
  parameter logic [BIT_D-1:0] BORDER = '1
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             start_i,
  input  logic [BIT_C-1:0] xy_0_i,
  input  logic [BIT_C-1:0] xy_1_i,
  roi_pad_axis_if.slave    s_axis,
  roi_pad_axis_if.master   m_axis,
  output logic             busy_o,
  output logic             err_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);

  state_t          state_q, state_nx;
  logic [CW-1:0]   cnt_x;
  logic [RW-1:0]   cnt_y;
  logic [XW-1:0]   xl_q, xr_q, x0, x1, px;
  logic [YW-1:0]   yt_q, yb_q, y0, y1, py;
  logic            tail_q, err_q;
  logic            coords_ok, in_roi, at_br, at_end, ld_rdy, load, s_hs;
  logic [BIT_D-1:0] pad_val, data_in;

  assign x0 = get_x(32'(xy_0_i));
  assign y0 = get_y(32'(xy_0_i));
  assign x1 = get_x(32'(xy_1_i));
  assign y1 = get_y(32'(xy_1_i));
  assign coords_ok = (x0 < XW'(WIDTH)) && (x1 < XW'(WIDTH)) &&
                     (y0 < YW'(HEIGHT)) && (y1 < YW'(HEIGHT));

  assign px     = XW'(cnt_x);
  assign py     = YW'(cnt_y);
  assign in_roi = (px >= xl_q) && (px <= xr_q) && (py >= yt_q) && (py <= yb_q);
  assign at_br  = (px == xr_q) && (py == yb_q);
  assign at_end = (cnt_x == CW'(WIDTH - 1)) && (cnt_y == RW'(HEIGHT - 1));

`ifdef ROI_BORDER_EN
  // One extra bit so xl-1 / yt-1 cannot underflow at the frame edge.
  logic in_ring;
  assign in_ring = ({1'b0, px} + (XW+1)'(1) >= {1'b0, xl_q}) &&
                   ({1'b0, px} <= {1'b0, xr_q} + (XW+1)'(1)) &&
                   ({1'b0, py} + (YW+1)'(1) >= {1'b0, yt_q}) &&
                   ({1'b0, py} <= {1'b0, yb_q} + (YW+1)'(1));
  assign pad_val = in_ring ? BORDER : FILL;
`else
  assign pad_val = FILL;
`endif

  // tail_q blocks a wrapped (0,0) load while the final beat waits for acceptance.
  assign load  = (state_q == FRAME) && !tail_q && ld_rdy && (!in_roi || s_axis.tvalid);
  assign s_axis.tready = (state_q == FRAME) && !tail_q && in_roi && ld_rdy;
  assign s_hs    = s_axis.tvalid && s_axis.tready;
  assign data_in = in_roi ? s_axis.tdata : pad_val;

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:  if (start_i && coords_ok) state_nx = FRAME;
      FRAME: if (m_axis.tvalid && m_axis.tready && m_axis.tlast) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      cnt_x   <= '0;
      cnt_y   <= '0;
      xl_q    <= '0;
      xr_q    <= '0;
      yt_q    <= '0;
      yb_q    <= '0;
      tail_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (state_q == IDLE && start_i) begin
        if (coords_ok) begin
          xl_q   <= (x0 < x1) ? x0 : x1;
          xr_q   <= (x0 < x1) ? x1 : x0;
          yt_q   <= (y0 < y1) ? y0 : y1;
          yb_q   <= (y0 < y1) ? y1 : y0;
          cnt_x  <= '0;
          cnt_y  <= '0;
          tail_q <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (load) begin
        if (cnt_x == CW'(WIDTH - 1)) begin
          cnt_x <= '0;
          cnt_y <= (cnt_y == RW'(HEIGHT - 1)) ? '0 : cnt_y + RW'(1);
        end else begin
          cnt_x <= cnt_x + CW'(1);
        end
        if (at_end) tail_q <= 1'b1;
      end
      if (s_hs && (at_br != s_axis.tlast)) err_q <= 1'b1;
    end
  end

  axis_out_reg #(.BIT_D(BIT_D)) u_out (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .load_i   (load),
    .data_i   (data_in),
    .last_i   (at_end),
    .user_i   ((cnt_x == '0) && (cnt_y == '0)),
    .ld_rdy_o (ld_rdy),
    .m_axis   (m_axis)
  );

  assign busy_o = (state_q == FRAME);
  assign err_o  = err_q;

endmodule

// File: tb/tb_roi_pad_axis.sv
// Scoreboard bench for roi_pad_axis on an 8x6 frame.
module tb_roi_pad_axis;

  localparam int W = 8;
  localparam int H = 6;
`ifdef ROI_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] xy0 = '0;
  logic [31:0] xy1 = '0;
  logic        busy, err;

  roi_pad_axis_if #(.BIT_D(8)) s_if ();
  roi_pad_axis_if #(.BIT_D(8)) m_if ();

  roi_pad_axis #(.WIDTH(W), .HEIGHT(H), .BIT_D(8), .BIT_C(32)) dut (
    .clk_i   (clk),
    .arst_i  (arst),
    .start_i (start),
    .xy_0_i  (xy0),
    .xy_1_i  (xy1),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .busy_o  (busy),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];
  int          acc_cnt = 0;
  int          rxl = 0, rxr = -1, ryt = 0, ryb = -1;
  bit          rnd_rdy = 1'b0;
  bit          abort = 1'b0;
  bit          prev_stall = 1'b0;
  logic [9:0]  prev_beat = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_roi(input int x, input int y);
    return x >= rxl && x <= rxr && y >= ryt && y <= ryb;
  endfunction

  function automatic bit in_ring(input int x, input int y);
    return x >= rxl - 1 && x <= rxr + 1 && y >= ryt - 1 && y <= ryb + 1 && !in_roi(x, y);
  endfunction

  function automatic bit roi_at(input int l);
    if (l >= W * H) return 1'b0;
    return in_roi(l % W, l / W);
  endfunction

  initial begin
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    m_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    logic [9:0]  got;
    if (!arst) begin
      got = {m_if.tdata, m_if.tlast, m_if.tuser};
      if (prev_stall) chk("hold", {21'd0, m_if.tvalid, got}, {21'd0, 1'b1, prev_beat});
      if (s_if.tready) chk("s_tready_roi", 32'(roi_at(acc_cnt + int'(m_if.tvalid))), 1);
      if (m_if.tvalid && m_if.tready) begin
        e = (sb.size() == 0) ? 32'hFFFF_FFFF : sb.pop_front();
        chk("beat", {22'd0, got}, e);
        acc_cnt++;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_beat  = got;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [31:0] pack(input int x, input int y);
    return (32'(x) << 16) | 32'(y);
  endfunction

  task automatic do_reset();
    arst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic prep_frame(input int x0, input int y0, input int x1, input int y1, input bit rnd);
    int k = 0;
    rxl = (x0 < x1) ? x0 : x1;  rxr = (x0 < x1) ? x1 : x0;
    ryt = (y0 < y1) ? y0 : y1;  ryb = (y0 < y1) ? y1 : y0;
    sb.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        logic [7:0] d;
        if (in_roi(x, y)) begin k++; d = 8'(k); end
        else d = (BORDER_EN && in_ring(x, y)) ? 8'hFF : 8'h00;
        sb.push_back({22'd0, d, 1'(x == W - 1 && y == H - 1), 1'(x == 0 && y == 0)});
      end
    acc_cnt = 0;
    abort   = 1'b0;
    rnd_rdy = rnd;
    xy0 = pack(x0, y0);
    xy1 = pack(x1, y1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_src(input int n, input int last_at, input bit gaps);
    for (int i = 0; i < n && !abort; i++) begin
      bit hs = 1'b0;
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
          s_if.tvalid = 1'b0;
          @(posedge clk); #1;
        end
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(i + 1);
      s_if.tlast  = (i == last_at);
      for (int t = 0; t < 400 && !hs && !abort; t++) begin
        @(negedge clk);
        hs = s_if.tready;
        @(posedge clk); #1;
      end
      if (!hs && !abort) chk("src_timeout", 32'(s_if.tready), 1);
      if (hs && i == last_at && last_at != n - 1) chk("err_early", 32'(err), 1);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 2000 && (sb.size() != 0 || busy); c++) begin
      @(posedge clk); #1;
    end
    chk("drain_left", 32'(sb.size()), 0);
    chk("drain_busy", 32'(busy), 0);
  endtask

  task automatic run_frame(input int x0, input int y0, input int x1, input int y1,
                           input int last_at, input bit gaps, input bit rnd, input bit exp_err);
    int n;
    prep_frame(x0, y0, x1, y1, rnd);
    chk("busy_on", 32'(busy), 1);
    n = (rxr - rxl + 1) * (ryb - ryt + 1);
    drive_src(n, last_at, gaps);
    wait_drain();
    chk("beats", 32'(acc_cnt), 48);
    chk("err", 32'(err), 32'(exp_err));
    rnd_rdy = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_tvalid", 32'(m_if.tvalid), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_err",    32'(err), 0);
    chk("rst_tready", 32'(s_if.tready), 0);
    chk("rst_flags",  {30'd0, m_if.tlast, m_if.tuser}, 0);

    run_frame(2, 1, 4, 2, 5, 1'b0, 1'b0, 1'b0);
    run_frame(4, 2, 2, 1, 5, 1'b0, 1'b0, 1'b0);
    run_frame(2, 1, 4, 2, 5, 1'b1, 1'b1, 1'b0);
    run_frame(3, 3, 3, 3, 0, 1'b1, 1'b1, 1'b0);
    run_frame(0, 0, 7, 5, 47, 1'b0, 1'b0, 1'b0);
    run_frame(7, 5, 0, 0, 47, 1'b1, 1'b1, 1'b0);
    run_frame(0, 0, 1, 1, 3, 1'b0, 1'b0, 1'b0);

    run_frame(2, 1, 4, 2, 2, 1'b0, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", 32'(err), 1);
    do_reset();
    chk("err_cleared", 32'(err), 0);

    xy0 = pack(2, 1);
    xy1 = pack(8, 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bad_err", 32'(err), 1);
    for (int c = 0; c < 10; c++) begin
      chk("bad_busy", {30'd0, busy, m_if.tvalid}, 0);
      @(posedge clk); #1;
    end
    do_reset();

    prep_frame(2, 1, 4, 2, 1'b0);
    fork
      drive_src(6, 5, 1'b0);
      begin
        for (int c = 0; c < 500 && acc_cnt < 20; c++) begin
          @(posedge clk); #1;
        end
        chk("mid_reach20", 32'(acc_cnt >= 20), 1);
        abort = 1'b1;
        arst  = 1'b1;
        @(posedge clk); #1;
        chk("mid_tvalid", 32'(m_if.tvalid), 0);
        chk("mid_busy",   32'(busy), 0);
        arst = 1'b0;
      end
    join
    sb.delete();
    run_frame(2, 1, 4, 2, 5, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
